// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the single-port data memory between the core load/store port
// (requester C) and an auxiliary load/test port (requester A).
//
// Arbitration:
//    - Decided combinationally each cycle from the requests and registered state.
//    - Round-robin per beat.
//    - The current owner may keep the memory for up to MAX_HOLD consecutive
//      beats while the other requester waits.
//
// Writes are gated off for out-of-range addresses. Reads return registered
// data with a one-cycle rvalid strobe in the cycle after the granting edge.
//
// Parameters
//    DMEM_SIZE  memory depth in 32-bit words; byte addresses >= DMEM_SIZE*4
//               are out of range
//    MAX_HOLD   maximum consecutive beats for one owner under contention (1..15)
//
// Ports
//    clk                 single clock, rising edge
//    reset               asynchronous, active-low reset
//    c_req/c_we          core beat request and direction (1 = write)
//    c_addr/c_wdata      core byte address (bits [1:0] ignored) and write data
//    c_gnt               core beat accepted at the next rising edge
//    c_rvalid/c_rdata    core read strobe and registered read data
//    a_*                 same set for the auxiliary requester
//    m_we/m_addr/m_wdata memory write enable, byte address, write data
//    m_rdata             memory combinational read data for m_addr
//    err                 strobe: the previous granted beat was out of range
// ---------------------------------------------------------------------------
module dmem_arbiter #(
   parameter int DMEM_SIZE = 64,
   parameter int MAX_HOLD  = 4
) (
   input  logic        clk,
   input  logic        reset,

   input  logic        c_req,
   input  logic        c_we,
   input  logic [31:0] c_addr,
   input  logic [31:0] c_wdata,
   output logic        c_gnt,
   output logic        c_rvalid,
   output logic [31:0] c_rdata,

   input  logic        a_req,
   input  logic        a_we,
   input  logic [31:0] a_addr,
   input  logic [31:0] a_wdata,
   output logic        a_gnt,
   output logic        a_rvalid,
   output logic [31:0] a_rdata,

   output logic        m_we,
   output logic [31:0] m_addr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,

   output logic        err
);

   // State encodes who owned the most recent granted beat; IDLE means the
   // previous cycle carried no beat at all.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_C = 2'd1,
      OWN_A = 2'd2
   } state_t;

   localparam logic OWNER_C = 1'b0;
   localparam logic OWNER_A = 1'b1;

   localparam logic [3:0]  HOLD_LIMIT = 4'(MAX_HOLD);
   localparam logic [3:0]  HOLD_SAT   = 4'd15;
   localparam logic [29:0] WORD_LIMIT = 30'(DMEM_SIZE);

   state_t      state_q, state_d;
   logic        last_q, last_d;
   logic [3:0]  hold_cnt_q, hold_cnt_d;
   logic        c_rvalid_q, c_rvalid_d;
   logic        a_rvalid_q, a_rvalid_d;
   logic [31:0] c_rdata_q, c_rdata_d;
   logic [31:0] a_rdata_q, a_rdata_d;
   logic        err_q, err_d;

   logic        grant_c;
   logic        grant_a;
   logic        granted;
   logic        sel_we;
   logic        in_range;
   logic        owner_keeps;
   logic [31:0] read_value;

   // Grant decision.
   // The reset input gates everything so that no grant or write can leak
   // out while the block is held in reset.
   // Under contention the owner is kept while its hold window is still
   // open; otherwise the requester that did not win last time gets the beat.
   // last_q resets to A, so C wins the first tie after reset.
   always_comb begin
      grant_c     = 1'b0;
      grant_a     = 1'b0;
      owner_keeps = (hold_cnt_q < HOLD_LIMIT);
      if (reset) begin
         if (c_req && !a_req) begin
            grant_c = 1'b1;
         end else if (a_req && !c_req) begin
            grant_a = 1'b1;
         end else if (c_req && a_req) begin
            if (state_q == OWN_C && owner_keeps) begin
               grant_c = 1'b1;
            end else if (state_q == OWN_A && owner_keeps) begin
               grant_a = 1'b1;
            end else if (last_q == OWNER_A) begin
               grant_c = 1'b1;
            end else begin
               grant_a = 1'b1;
            end
         end
      end
   end

   // Memory-side mux.
   // C drives the bus whenever A is not granted, including idle cycles.
   // The range check uses the word index only, since the byte offset bits
   // are ignored.
   always_comb begin
      granted  = grant_c | grant_a;
      m_addr   = grant_a ? a_addr  : c_addr;
      m_wdata  = grant_a ? a_wdata : c_wdata;
      sel_we   = grant_a ? a_we    : c_we;
      in_range = (m_addr[31:2] < WORD_LIMIT);
      m_we     = granted & sel_we & in_range;
   end

   // Out-of-range reads return zero instead of whatever the memory drives.
   always_comb begin
      read_value = in_range ? m_rdata : 32'h0000_0000;
   end

   // Next-state logic: ownership state, round-robin memory, hold counter,
   // read capture and error strobe.
   // The hold counter restarts at 1 whenever ownership changes or a beat
   // follows an idle cycle. It saturates at 15 so that an uncontended owner
   // streaming forever cannot wrap and reopen its window.
   always_comb begin
      state_d    = IDLE;
      last_d     = last_q;
      hold_cnt_d = 4'd0;
      c_rvalid_d = 1'b0;
      a_rvalid_d = 1'b0;
      c_rdata_d  = c_rdata_q;
      a_rdata_d  = a_rdata_q;
      err_d      = 1'b0;

      if (grant_c) begin
         state_d = OWN_C;
         last_d  = OWNER_C;
         if (state_q == OWN_C) begin
            hold_cnt_d = (hold_cnt_q == HOLD_SAT) ? HOLD_SAT : hold_cnt_q + 4'd1;
         end else begin
            hold_cnt_d = 4'd1;
         end
         if (!c_we) begin
            c_rvalid_d = 1'b1;
            c_rdata_d  = read_value;
         end
      end else if (grant_a) begin
         state_d = OWN_A;
         last_d  = OWNER_A;
         if (state_q == OWN_A) begin
            hold_cnt_d = (hold_cnt_q == HOLD_SAT) ? HOLD_SAT : hold_cnt_q + 4'd1;
         end else begin
            hold_cnt_d = 4'd1;
         end
         if (!a_we) begin
            a_rvalid_d = 1'b1;
            a_rdata_d  = read_value;
         end
      end

      if (granted && !in_range) begin
         err_d = 1'b1;
      end
   end

   // State registers.
   // The asynchronous reset drops any pending rvalid immediately, so a read
   // granted just before reset never reports data.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         last_q     <= OWNER_A;
         hold_cnt_q <= 4'd0;
         c_rvalid_q <= 1'b0;
         a_rvalid_q <= 1'b0;
         c_rdata_q  <= 32'h0000_0000;
         a_rdata_q  <= 32'h0000_0000;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         hold_cnt_q <= hold_cnt_d;
         c_rvalid_q <= c_rvalid_d;
         a_rvalid_q <= a_rvalid_d;
         c_rdata_q  <= c_rdata_d;
         a_rdata_q  <= a_rdata_d;
         err_q      <= err_d;
      end
   end

   assign c_gnt    = grant_c;
   assign a_gnt    = grant_a;
   assign c_rvalid = c_rvalid_q;
   assign a_rvalid = a_rvalid_q;
   assign c_rdata  = c_rdata_q;
   assign a_rdata  = a_rdata_q;
   assign err      = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter.
// Two instances share the same request inputs:
//    - dut4 uses MAX_HOLD = 4 and is backed by a small word memory model.
//    - dut1 uses MAX_HOLD = 1 and is used for the strict-alternation case.
// Inputs are driven on the falling edge. Outputs are sampled 1 ns later.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

   logic        clk;
   logic        reset;
   logic        c_req, c_we, a_req, a_we;
   logic [31:0] c_addr, c_wdata, a_addr, a_wdata;

   logic        c_gnt_4, c_rvalid_4, a_gnt_4, a_rvalid_4, m_we_4, err_4;
   logic [31:0] c_rdata_4, a_rdata_4, m_addr_4, m_wdata_4, m_rdata_4;

   logic        c_gnt_1, c_rvalid_1, a_gnt_1, a_rvalid_1, m_we_1, err_1;
   logic [31:0] c_rdata_1, a_rdata_1, m_addr_1, m_wdata_1, m_rdata_1;

   logic [31:0] mem [0:63];

   int errors;
   int checks;

   dmem_arbiter #(.DMEM_SIZE(64), .MAX_HOLD(4)) dut4 (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt_4), .c_rvalid(c_rvalid_4), .c_rdata(c_rdata_4),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt_4), .a_rvalid(a_rvalid_4), .a_rdata(a_rdata_4),
      .m_we(m_we_4), .m_addr(m_addr_4), .m_wdata(m_wdata_4), .m_rdata(m_rdata_4),
      .err(err_4)
   );

   dmem_arbiter #(.DMEM_SIZE(64), .MAX_HOLD(1)) dut1 (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt_1), .c_rvalid(c_rvalid_1), .c_rdata(c_rdata_1),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt_1), .a_rvalid(a_rvalid_1), .a_rdata(a_rdata_1),
      .m_we(m_we_1), .m_addr(m_addr_1), .m_wdata(m_wdata_1), .m_rdata(m_rdata_1),
      .err(err_1)
   );

   // Clock generation
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word memory behind dut4. An out-of-range address returns a nonzero
   // pattern, so that the arbiter's zeroing of such reads is visible.
   assign m_rdata_4 = (m_addr_4 < 32'd256) ? mem[m_addr_4[7:2]] : 32'hA5A5_A5A5;
   assign m_rdata_1 = 32'h0000_0000;

   always @(posedge clk) begin
      if (m_we_4 && m_addr_4 < 32'd256) begin
         mem[m_addr_4[7:2]] <= m_wdata_4;
      end
   end

   // Helper to release both requesters
   task automatic idle_inputs();
      c_req   = 1'b0;
      c_we    = 1'b0;
      c_addr  = 32'h0;
      c_wdata = 32'h0;
      a_req   = 1'b0;
      a_we    = 1'b0;
      a_addr  = 32'h0;
      a_wdata = 32'h0;
   endtask

   // Reset and idle: both requesting during reset gives no grant and no write
   task automatic test_reset();
      reset   = 1'b0;
      c_req   = 1'b1;
      c_we    = 1'b1;
      c_addr  = 32'h20;
      c_wdata = 32'h1111_2222;
      a_req   = 1'b1;
      a_we    = 1'b1;
      a_addr  = 32'h40;
      a_wdata = 32'h3333_4444;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         checks++;
         if ({c_gnt_4, a_gnt_4, m_we_4} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_gnt cycle %0d: got c_gnt/a_gnt/m_we=%b%b%b, expected 000",
                     i, c_gnt_4, a_gnt_4, m_we_4);
         end
         checks++;
         if ({c_rvalid_4, a_rvalid_4, err_4} !== 3'b000 || c_rdata_4 !== 32'h0 || a_rdata_4 !== 32'h0) begin
            errors++;
            $display("[TB] FAIL reset_regs: got rvalid c/a=%b%b err=%b c_rdata=%h a_rdata=%h, expected all zero",
                     c_rvalid_4, a_rvalid_4, err_4, c_rdata_4, a_rdata_4);
         end
         checks++;
         if (m_addr_4 !== 32'h20 || m_wdata_4 !== 32'h1111_2222) begin
            errors++;
            $display("[TB] FAIL reset_mux: got m_addr=%h m_wdata=%h, expected 00000020 11112222",
                     m_addr_4, m_wdata_4);
         end
      end
      // Release with both still requesting: C must win the first tie
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (c_gnt_4 !== 1'b1 || a_gnt_4 !== 1'b0 || c_gnt_1 !== 1'b1 || a_gnt_1 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_release_tie: got dut4 c/a=%b%b dut1 c/a=%b%b, expected 10 10",
                  c_gnt_4, a_gnt_4, c_gnt_1, a_gnt_1);
      end
      idle_inputs();
   endtask

   // Single requester: write 0xDEADBEEF to 0x10, then read it back
   task automatic test_write_read();
      @(negedge clk);
      c_req   = 1'b1;
      c_we    = 1'b1;
      c_addr  = 32'h10;
      c_wdata = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (c_gnt_4 !== 1'b1 || m_we_4 !== 1'b1 || m_addr_4 !== 32'h10 || m_wdata_4 !== 32'hDEAD_BEEF) begin
         errors++;
         $display("[TB] FAIL write_beat: got gnt=%b m_we=%b m_addr=%h m_wdata=%h, expected 1 1 00000010 deadbeef",
                  c_gnt_4, m_we_4, m_addr_4, m_wdata_4);
      end
      @(negedge clk);
      c_we = 1'b0;
      #1;
      checks++;
      if (c_gnt_4 !== 1'b1 || m_we_4 !== 1'b0 || c_rvalid_4 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL read_beat: got gnt=%b m_we=%b c_rvalid=%b, expected 1 0 0",
                  c_gnt_4, m_we_4, c_rvalid_4);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if (c_rvalid_4 !== 1'b1 || c_rdata_4 !== 32'hDEAD_BEEF || a_rvalid_4 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL read_data: got c_rvalid=%b c_rdata=%h a_rvalid=%b, expected 1 deadbeef 0",
                  c_rvalid_4, c_rdata_4, a_rvalid_4);
      end
      @(negedge clk);
      #1;
      checks++;
      if (c_rvalid_4 !== 1'b0 || c_rdata_4 !== 32'hDEAD_BEEF) begin
         errors++;
         $display("[TB] FAIL read_hold: got c_rvalid=%b c_rdata=%h, expected 0 deadbeef",
                  c_rvalid_4, c_rdata_4);
      end
   endtask

   // Continuous contention for 12 cycles, starting from a fresh reset.
   // Expected grants: dut4 gives C,C,C,C,A,A,A,A,C,C,C,C and dut1 alternates.
   task automatic test_contention();
      logic [11:0] exp_a4;
      logic        exp_a1;
      exp_a4 = 12'b0000_1111_0000;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset   = 1'b1;
      c_req   = 1'b1;
      c_addr  = 32'h10;
      a_req   = 1'b1;
      a_addr  = 32'h14;
      for (int i = 0; i < 12; i++) begin
         #1;
         exp_a1 = i[0];
         checks++;
         if (a_gnt_4 !== exp_a4[i] || c_gnt_4 !== ~exp_a4[i]) begin
            errors++;
            $display("[TB] FAIL contention_hold4 beat %0d: got c/a=%b%b, expected %b%b",
                     i, c_gnt_4, a_gnt_4, ~exp_a4[i], exp_a4[i]);
         end
         checks++;
         if (a_gnt_1 !== exp_a1 || c_gnt_1 !== ~exp_a1) begin
            errors++;
            $display("[TB] FAIL contention_hold1 beat %0d: got c/a=%b%b, expected %b%b",
                     i, c_gnt_1, a_gnt_1, ~exp_a1, exp_a1);
         end
         @(negedge clk);
      end
      idle_inputs();
   endtask

   // A alone for two beats, one idle cycle, then both request: C wins
   task automatic test_tie_after_idle();
      a_req  = 1'b1;
      a_addr = 32'h18;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if (a_gnt_4 !== 1'b1 || c_gnt_4 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL tie_a_alone beat %0d: got c/a=%b%b, expected 01", i, c_gnt_4, a_gnt_4);
         end
         @(negedge clk);
      end
      a_req = 1'b0;
      #1;
      checks++;
      if (a_gnt_4 !== 1'b0 || c_gnt_4 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL tie_idle: got c/a=%b%b, expected 00", c_gnt_4, a_gnt_4);
      end
      @(negedge clk);
      a_req  = 1'b1;
      c_req  = 1'b1;
      c_addr = 32'h1C;
      #1;
      checks++;
      if (c_gnt_4 !== 1'b1 || a_gnt_4 !== 1'b0 || c_gnt_1 !== 1'b1 || a_gnt_1 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL tie_after_idle: got dut4 c/a=%b%b dut1 c/a=%b%b, expected 10 10",
                  c_gnt_4, a_gnt_4, c_gnt_1, a_gnt_1);
      end
      // Next beat: dut4 keeps C inside its window, dut1 must switch to A
      @(negedge clk);
      #1;
      checks++;
      if (c_gnt_4 !== 1'b1 || a_gnt_1 !== 1'b1 || c_gnt_1 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL tie_second_beat: got dut4 c=%b dut1 c/a=%b%b, expected 1 01",
                  c_gnt_4, c_gnt_1, a_gnt_1);
      end
      @(negedge clk);
      idle_inputs();
   endtask

   // Range boundary, out-of-range write and read, err strobe
   task automatic test_out_of_range();
      @(negedge clk);
      a_req   = 1'b1;
      a_we    = 1'b1;
      a_addr  = 32'hFC;
      a_wdata = 32'h0BAD_F00D;
      #1;
      checks++;
      if (a_gnt_4 !== 1'b1 || m_we_4 !== 1'b1 || m_addr_4 !== 32'hFC) begin
         errors++;
         $display("[TB] FAIL last_word_write: got gnt=%b m_we=%b m_addr=%h, expected 1 1 000000fc",
                  a_gnt_4, m_we_4, m_addr_4);
      end
      // A reads 0x10 in range, to leave a nonzero a_rdata behind
      @(negedge clk);
      a_we   = 1'b0;
      a_addr = 32'h10;
      @(negedge clk);
      a_we    = 1'b1;
      a_addr  = 32'h100;
      a_wdata = 32'h1234_5678;
      #1;
      checks++;
      if (a_rvalid_4 !== 1'b1 || a_rdata_4 !== 32'hDEAD_BEEF || err_4 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL a_read_inrange: got a_rvalid=%b a_rdata=%h err=%b, expected 1 deadbeef 0",
                  a_rvalid_4, a_rdata_4, err_4);
      end
      checks++;
      if (a_gnt_4 !== 1'b1 || m_we_4 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL oor_write: got gnt=%b m_we=%b, expected 1 0", a_gnt_4, m_we_4);
      end
      @(negedge clk);
      a_we = 1'b0;
      #1;
      checks++;
      if (err_4 !== 1'b1 || a_rvalid_4 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL oor_write_err: got err=%b a_rvalid=%b, expected 1 0", err_4, a_rvalid_4);
      end
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if (a_rvalid_4 !== 1'b1 || a_rdata_4 !== 32'h0 || err_4 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL oor_read: got a_rvalid=%b a_rdata=%h err=%b, expected 1 00000000 1",
                  a_rvalid_4, a_rdata_4, err_4);
      end
      @(negedge clk);
      #1;
      checks++;
      if (err_4 !== 1'b0 || a_rvalid_4 !== 1'b0 || mem[63] !== 32'h0BAD_F00D) begin
         errors++;
         $display("[TB] FAIL oor_after: got err=%b a_rvalid=%b mem[63]=%h, expected 0 0 0badf00d",
                  err_4, a_rvalid_4, mem[63]);
      end
   endtask

   // A read is granted; reset is asserted before the rvalid cycle can be seen
   task automatic test_reset_mid_read();
      @(negedge clk);
      a_req  = 1'b1;
      a_we   = 1'b0;
      a_addr = 32'h10;
      #1;
      checks++;
      if (a_gnt_4 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mid_read_gnt: got a_gnt=%b, expected 1", a_gnt_4);
      end
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle_inputs();
      @(negedge clk);
      #1;
      checks++;
      if (a_rvalid_4 !== 1'b0 || a_rdata_4 !== 32'h0 || c_rdata_4 !== 32'h0 || err_4 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mid_read_reset: got a_rvalid=%b a_rdata=%h c_rdata=%h err=%b, expected 0 0 0 0",
                  a_rvalid_4, a_rdata_4, c_rdata_4, err_4);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (a_rvalid_4 !== 1'b0 || c_rvalid_4 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mid_read_dropped: got a_rvalid=%b c_rvalid=%b, expected 0 0",
                  a_rvalid_4, c_rvalid_4);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      for (int i = 0; i < 64; i++) begin
         mem[i] = 32'h0;
      end
      idle_inputs();
      test_reset();
      test_write_read();
      test_contention();
      test_tie_after_idle();
      test_out_of_range();
      test_reset_mid_read();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
